// File: rtl/serial_link_port_if.sv
// serial_link_port_if: I/O register bus control from the memory router to a peripheral
interface serial_link_port_if;
  logic [15:0] ioreg_addr;
  logic        ioreg_we_l;
  logic        ioreg_re_l;
  modport master (output ioreg_addr, output ioreg_we_l, output ioreg_re_l);
  modport slave  (input ioreg_addr, input ioreg_we_l, input ioreg_re_l);
endinterface

// File: rtl/serial_link_port.sv
// serial_link_port: SB/SC serial link controller with internal or external shift clock
module serial_link_port #(
  parameter logic [15:0] SB_ADDR  = 16'hFF01,
  parameter logic [15:0] SC_ADDR  = 16'hFF02,
  parameter int          CLK_DIV  = 512,
  parameter int          FAST_DIV = 16
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET_L,
  serial_link_port_if.slave         bus,
  inout  wire  [7:0]                IO_IOREG_DATA,
  output logic                      O_SCK,
  output logic                      O_SCK_OE,
  input  logic                      I_SCK,
  output logic                      O_SO,
  input  logic                      I_SI,
  output logic                      O_SERIAL_INT
);
  localparam int MAXD = (CLK_DIV > FAST_DIV) ? CLK_DIV : FAST_DIV;
  localparam int PW   = $clog2(MAXD);
  typedef enum logic [1:0] {IDLE, SHIFT_INT, SHIFT_EXT} state_t;
  state_t          state_q;
  logic [7:0]      sb_q;
  logic            busy_q;
  logic [1:0]      mode_q;
  logic            fast_q;
  logic [2:0]      bit_cnt_q;
  logic [PW-1:0]   per_cnt_q;
  logic            sck_q;
  logic            so_q;
  logic            int_q;
  logic [2:0]      sync_q;
  logic            sb_wr, sc_wr, sb_rd, sc_rd, rise, fall, lo_ev, shift, abort;
  logic [PW-1:0]   half, last;
  logic [7:0]      wdata, sc_val;
  assign wdata  = IO_IOREG_DATA;
  assign sb_wr  = !bus.ioreg_we_l && bus.ioreg_addr == SB_ADDR;
  assign sc_wr  = !bus.ioreg_we_l && bus.ioreg_addr == SC_ADDR;
  assign sb_rd  = !bus.ioreg_re_l && bus.ioreg_addr == SB_ADDR;
  assign sc_rd  = !bus.ioreg_re_l && bus.ioreg_addr == SC_ADDR;
  assign sc_val = {busy_q, 5'b11111, mode_q};
  assign IO_IOREG_DATA = sb_rd ? sb_q : sc_rd ? sc_val : 8'bz;
  assign rise   = sync_q[1] & ~sync_q[2];
  assign fall   = ~sync_q[1] & sync_q[2];
  assign half   = fast_q ? PW'(FAST_DIV / 2) : PW'(CLK_DIV / 2);
  assign last   = fast_q ? PW'(FAST_DIV - 1) : PW'(CLK_DIV - 1);
  assign lo_ev  = (state_q == SHIFT_INT && per_cnt_q == '0) || (state_q == SHIFT_EXT && fall);
  assign shift  = (state_q == SHIFT_INT && per_cnt_q == half) || (state_q == SHIFT_EXT && rise);
  assign abort  = sc_wr && !wdata[7] && state_q != IDLE;
  assign O_SCK        = sck_q;
  assign O_SCK_OE     = mode_q[0];
  assign O_SO         = so_q;
  assign O_SERIAL_INT = int_q;
  // Register file, transfer FSM, bit timing and SCK synchronizer; mode bits update even mid-transfer
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q   <= IDLE;
      sb_q      <= '0;
      busy_q    <= 1'b0;
      mode_q    <= '0;
      fast_q    <= 1'b0;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
      sck_q     <= 1'b1;
      so_q      <= 1'b1;
      int_q     <= 1'b0;
      sync_q    <= '1;
    end else begin
      int_q  <= 1'b0;
      sync_q <= {sync_q[1:0], I_SCK};
      if (sc_wr) mode_q <= wdata[1:0];
      if (state_q == IDLE) begin
        if (sb_wr) sb_q <= wdata;
        if (sc_wr && wdata[7]) begin
          busy_q    <= 1'b1;
          fast_q    <= wdata[1];
          bit_cnt_q <= '0;
          per_cnt_q <= '0;
          state_q   <= wdata[0] ? SHIFT_INT : SHIFT_EXT;
        end
      end else if (abort) begin
        state_q <= IDLE;
        sck_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        if (state_q == SHIFT_INT) per_cnt_q <= (per_cnt_q == last) ? '0 : per_cnt_q + 1'b1;
        if (lo_ev) begin
          if (state_q == SHIFT_INT) sck_q <= 1'b0;
          so_q <= sb_q[7];
        end
        if (shift) begin
          sck_q     <= 1'b1;
          sb_q      <= {sb_q[6:0], I_SI};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            busy_q  <= 1'b0;
            int_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_link_port.sv
// tb_serial_link_port: scoreboard bench for the serial link SB/SC controller
module tb_serial_link_port;
  localparam int CD = 8;
  localparam int FD = 4;
  localparam logic [15:0] SB = 16'hFF01;
  localparam logic [15:0] SC = 16'hFF02;
  logic I_CLK = 1'b0;
  logic I_RESET_L = 1'b0;
  logic I_SCK = 1'b1;
  logic I_SI = 1'b0;
  logic O_SCK, O_SCK_OE, O_SO, O_SERIAL_INT;
  wire  [7:0] IO_IOREG_DATA;
  logic drv = 1'b0;
  logic [7:0] wdat = '0;
  logic [7:0] rv;
  int checks = 0, errors = 0, cyc = 0, rises = 0, low_w = 0, exp_low = CD / 2, nstart;
  logic mon_en = 1'b1, sck_prev = 1'b1;
  int   exp_int[$];
  logic exp_so[$];
  serial_link_port_if bus();
  assign IO_IOREG_DATA = drv ? wdat : 8'bz;
  serial_link_port #(.SB_ADDR(SB), .SC_ADDR(SC), .CLK_DIV(CD), .FAST_DIV(FD)) dut (
    .I_CLK(I_CLK), .I_RESET_L(I_RESET_L), .bus(bus), .IO_IOREG_DATA(IO_IOREG_DATA),
    .O_SCK(O_SCK), .O_SCK_OE(O_SCK_OE), .I_SCK(I_SCK), .O_SO(O_SO), .I_SI(I_SI),
    .O_SERIAL_INT(O_SERIAL_INT)
  );
  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic sw(input logic [15:0] a, input logic [7:0] d);
    @(negedge I_CLK);
    bus.ioreg_addr = a; wdat = d; drv = 1'b1; bus.ioreg_we_l = 1'b0;
    @(negedge I_CLK);
    bus.ioreg_we_l = 1'b1; drv = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    @(negedge I_CLK);
    bus.ioreg_addr = a; bus.ioreg_re_l = 1'b0;
    #1 v = IO_IOREG_DATA;
    bus.ioreg_re_l = 1'b1;
  endtask
  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] e);
    logic [7:0] v;
    rd(a, v);
    chk(tag, v, e);
  endtask
  task automatic wait_sck(input logic v);
    for (int i = 0; i < 4 * CD; i++) begin
      if (O_SCK == v) return;
      @(negedge I_CLK);
    end
    chk("sck_timeout", O_SCK, v);
  endtask
  task automatic wait_rises(input int n);
    for (int i = 0; i < 16 * CD; i++) begin
      if (rises >= n) return;
      @(negedge I_CLK);
    end
    chk("rise_timeout", rises, n);
  endtask
  task automatic wait_int_done();
    for (int i = 0; i < 20 * CD; i++) begin
      if (exp_int.size() == 0) return;
      @(negedge I_CLK);
    end
    chk("int_timeout", exp_int.size(), 0);
    exp_int.delete();
  endtask
  task automatic push_so(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_so.push_back(b[7 - i]);
  endtask
  task automatic int_xfer(input logic [7:0] sb, input logic [7:0] sc, input logic [7:0] si, input int div);
    exp_low = div / 2;
    rises = 0;
    sw(SB, sb);
    sw(SC, sc);
    nstart = cyc;
    exp_int.push_back(nstart + 1 + 7 * div + div / 2);
    push_so(sb, 8);
    chk("sck_oe_int", O_SCK_OE, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_sck(1'b0);
      I_SI = si[7 - k];
      wait_sck(1'b1);
    end
    wait_int_done();
    chk("rises", rises, 8);
  endtask
  initial begin
    forever begin
      @(negedge I_CLK);
      if (O_SERIAL_INT) begin
        if (exp_int.size() == 0) chk("int_unexpected", 1, 0);
        else chk("int_cycle", cyc, exp_int.pop_front());
      end
      if (mon_en) begin
        if (!O_SCK) low_w++;
        else if (!sck_prev) begin
          rises++;
          chk("sck_low_width", low_w, exp_low);
          if (exp_so.size() == 0) chk("so_unexpected", 1, 0);
          else chk("so_bit", O_SO, exp_so.pop_front());
          low_w = 0;
        end
      end else low_w = 0;
      sck_prev = O_SCK;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.ioreg_addr = '0; bus.ioreg_we_l = 1'b1; bus.ioreg_re_l = 1'b1;
    repeat (3) @(negedge I_CLK);
    I_RESET_L = 1'b1;
    rd_chk("rst_sb", SB, 8'h00);
    rd_chk("rst_sc", SC, 8'h7C);
    chk("rst_sck", O_SCK, 1'b1);
    chk("rst_so", O_SO, 1'b1);
    chk("rst_int", O_SERIAL_INT, 1'b0);
    int_xfer(8'hA5, 8'h81, 8'h3C, CD);
    rd_chk("int_sb", SB, 8'h3C);
    rd_chk("int_sc", SC, 8'h7D);
    int_xfer(8'h3C, 8'h83, 8'h00, FD);
    rd_chk("fast_sb", SB, 8'h00);
    rd_chk("fast_sc", SC, 8'h7F);
    exp_low = CD / 2;
    I_SI = 1'b1;
    sw(SB, 8'h0F);
    sw(SC, 8'h80);
    push_so(8'h0F, 8);
    chk("sck_oe_ext", O_SCK_OE, 1'b0);
    repeat (40) @(negedge I_CLK);
    rd_chk("ext_wait_sc", SC, 8'hFC);
    for (int k = 0; k < 8; k++) begin
      I_SCK = 1'b0;
      repeat (6) @(negedge I_CLK);
      chk("ext_so", O_SO, exp_so.pop_front());
      I_SCK = 1'b1;
      if (k == 7) exp_int.push_back(cyc + 3);
      repeat (6) @(negedge I_CLK);
    end
    wait_int_done();
    rd_chk("ext_sb", SB, 8'hFF);
    rd_chk("ext_sc", SC, 8'h7C);
    I_SI = 1'b0;
    rises = 0;
    sw(SB, 8'hFF);
    sw(SC, 8'h81);
    push_so(8'hFF, 3);
    wait_rises(3);
    sw(SB, 8'h00);
    sw(SC, 8'h01);
    chk("abort_sck", O_SCK, 1'b1);
    repeat (100) @(negedge I_CLK);
    chk("abort_so_left", exp_so.size(), 0);
    chk("abort_rises", rises, 3);
    rd_chk("abort_sb", SB, 8'hF8);
    rd_chk("abort_sc", SC, 8'h7D);
    rises = 0;
    sw(SB, 8'hFF);
    sw(SC, 8'h81);
    push_so(8'hFF, 3);
    wait_rises(3);
    wait_sck(1'b0);
    mon_en = 1'b0;
    #3 I_RESET_L = 1'b0;
    #1;
    chk("mid_rst_sck", O_SCK, 1'b1);
    chk("mid_rst_so", O_SO, 1'b1);
    chk("mid_rst_int", O_SERIAL_INT, 1'b0);
    exp_so.delete();
    @(negedge I_CLK);
    I_RESET_L = 1'b1;
    repeat (100) @(negedge I_CLK);
    mon_en = 1'b1;
    rd_chk("mid_rst_sb", SB, 8'h00);
    rd_chk("mid_rst_sc", SC, 8'h7C);
    chk("mid_rst_sck_after", O_SCK, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
